// File: rtl/inst_sram_if.sv
// inst_sram_if
//   Fetch-side responder between the PC register / ctrl unit and an SRAM-like
//   instruction bus. Each word-aligned fetch PC becomes one bus read. stallreq_o
//   stays high until the word for the current PC is back. A pipeline flush
//   cancels the fetch, and any read already on the bus is drained and dropped.
//
//   state   | meaning
//   IDLE    | no read in flight; issues a request straight from pc_i
//   REQ     | request raised, waiting for addr_ok (address held in addr_r)
//   WAIT    | request accepted, waiting for data_ok
//   HOLD    | word delivered while IF/ID held; replay it from buf_r
//   DISCARD | flushed read still on the bus; swallow its data_ok
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   ce_i, pc_i          fetch enable and virtual fetch address
//   stall_i             ctrl stall vector; only stall_i[1] (IF/ID hold) is used
//   flush_i             pipeline flush
//   inst_o, stallreq_o  instruction to IF/ID, IF stall request
//   inst_req .. inst_wdata        bus request side
//   inst_addr_ok, inst_data_ok, inst_rdata  bus response side
module inst_sram_if #(
  parameter int unsigned SEG_MAP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic [31:0] pc_i,
  input  logic [5:0]  stall_i,
  input  logic        flush_i,
  output logic [31:0] inst_o,
  output logic        stallreq_o,
  output logic        inst_req,
  output logic        inst_wr,
  output logic [1:0]  inst_size,
  output logic [31:0] inst_addr,
  output logic [31:0] inst_wdata,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_REQ     = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_HOLD    = 3'd3;
  localparam logic [2:0] S_DISCARD = 3'd4;

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [31:0] addr_r;
  logic [31:0] buf_r;
  logic        fl_r;
  logic        fetchable;
  logic [31:0] paddr;
  logic        unused_stall;

  assign unused_stall = ^{stall_i[5:2], stall_i[0]};

  assign inst_wr    = 1'b0;
  assign inst_size  = 2'b10;
  assign inst_wdata = 32'h0;

  // Misaligned PCs never reach the bus; the address error is taken elsewhere.
  assign fetchable = ce_i & ~flush_i & (pc_i[1:0] == 2'b00);
  assign paddr     = (SEG_MAP != 0) ? {3'b000, pc_i[28:0]} : pc_i;

  always_comb begin
    state_nxt  = state;
    inst_req   = 1'b0;
    stallreq_o = 1'b0;
    inst_o     = 32'h0;
    inst_addr  = addr_r;
    case (state)
      S_IDLE: begin
        inst_addr  = paddr;
        inst_req   = fetchable;
        stallreq_o = fetchable;
        if (fetchable) state_nxt = inst_addr_ok ? S_WAIT : S_REQ;
      end
      S_REQ: begin
        inst_req   = 1'b1;
        stallreq_o = 1'b1;
        // A flush seen at any point in REQ still lets the request complete,
        // but its data must be thrown away.
        if (inst_addr_ok) state_nxt = (fl_r | flush_i) ? S_DISCARD : S_WAIT;
      end
      S_WAIT: begin
        if (inst_data_ok) begin
          if (flush_i) begin
            state_nxt = S_IDLE;
          end else begin
            inst_o    = inst_rdata;
            state_nxt = stall_i[1] ? S_HOLD : S_IDLE;
          end
        end else begin
          stallreq_o = 1'b1;
          if (flush_i) state_nxt = S_DISCARD;
        end
      end
      S_HOLD: begin
        inst_o = buf_r;
        if (~stall_i[1] | flush_i) state_nxt = S_IDLE;
      end
      S_DISCARD: begin
        stallreq_o = 1'b1;
        if (inst_data_ok) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (flush_i) stallreq_o = 1'b0;
    // Outputs are quiet during reset even though IDLE would otherwise
    // request straight from pc_i.
    if (rst) begin
      inst_req   = 1'b0;
      stallreq_o = 1'b0;
      inst_o     = 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      addr_r <= 32'h0;
      buf_r  <= 32'h0;
      fl_r   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && fetchable) addr_r <= paddr;
      if (state == S_IDLE)                     fl_r <= 1'b0;
      else if (state == S_REQ && flush_i)      fl_r <= 1'b1;
      if (state == S_WAIT && inst_data_ok && ~flush_i) buf_r <= inst_rdata;
    end
  end

endmodule

// File: tb/tb_inst_sram_if.sv
// tb_inst_sram_if
//   Drives fetches into inst_sram_if through a behavioural bus responder with
//   programmable addr_ok / data_ok latencies and a fixed address->word memory.
//   Each fetch is judged at transaction level: the word returned, the address
//   accepted on the bus, the number of stalled cycles, and HOLD replay.
module tb_inst_sram_if;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce_i;
  logic [31:0] pc_i;
  logic [5:0]  stall_i;
  logic        flush_i;
  logic [31:0] inst_o;
  logic        stallreq_o;
  logic        inst_req;
  logic        inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic [31:0] inst_wdata;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  always #5 clk = ~clk;

  inst_sram_if dut (
    .clk          (clk),
    .rst          (rst),
    .ce_i         (ce_i),
    .pc_i         (pc_i),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .inst_o       (inst_o),
    .stallreq_o   (stallreq_o),
    .inst_req     (inst_req),
    .inst_wr      (inst_wr),
    .inst_size    (inst_size),
    .inst_addr    (inst_addr),
    .inst_wdata   (inst_wdata),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata)
  );

  int checks = 0;
  int errors = 0;

  // responder state
  int          alat;
  int          dlat;
  int          req_cnt;
  bit          pending;
  int          data_cnt;
  int          data_due;
  logic [31:0] acc_addr;
  bit          last_req;
  logic [31:0] last_req_addr;
  int          acc_count;
  logic [31:0] acc_last;

  // values sampled mid-cycle
  logic        s_req;
  logic        s_aok;
  logic        s_dok;
  logic        s_stall;
  logic        s_rst;
  logic [31:0] s_addr;
  logic [31:0] s_inst;

  function automatic logic [31:0] pmap(input logic [31:0] v);
    return {3'b000, v[28:0]};
  endfunction

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h1FC0_0000) return 32'h3C01_1234;
    return ({a[15:0], a[31:16]} ^ 32'h5A5A_C3C3) + 32'h0001_0001;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic resp_reset();
    req_cnt   = 0;
    pending   = 0;
    data_cnt  = 0;
    data_due  = 1;
    last_req  = 0;
    last_req_addr = 32'h0;
    acc_addr  = 32'h0;
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic cyc();
    #1;
    inst_addr_ok = inst_req && (req_cnt >= alat);
    inst_data_ok = pending && (data_cnt + 1 >= data_due);
    inst_rdata   = inst_data_ok ? mem(acc_addr) : $urandom;
    #1;
    s_req   = inst_req;
    s_aok   = inst_addr_ok;
    s_dok   = inst_data_ok;
    s_addr  = inst_addr;
    s_stall = stallreq_o;
    s_inst  = inst_o;
    s_rst   = rst;
    if (s_req && last_req) chk("addr_stable", s_addr, last_req_addr);
    if (s_req) chk("single_outstanding", 32'(pending), 32'h0);
    @(posedge clk);
    if (s_dok) pending = 0;
    else if (pending) data_cnt++;
    if (s_req && s_aok) begin
      pending   = 1;
      data_cnt  = 0;
      data_due  = dlat;
      acc_addr  = s_addr;
      acc_last  = s_addr;
      acc_count++;
      req_cnt   = 0;
    end else if (s_req) begin
      req_cnt++;
    end else begin
      req_cnt = 0;
    end
    last_req      = s_req && !s_aok;
    last_req_addr = s_addr;
    if (s_rst) resp_reset();
    @(negedge clk);
  endtask

  // One complete fetch of pc with addr_ok after a cycles of req, data_ok d
  // cycles after acceptance, IF/ID held for hold cycles after delivery, and
  // an optional one-cycle flush at stalled-cycle index flush_at that
  // redirects the fetch to newpc.
  task automatic run_fetch(input logic [31:0] pc, input int a, input int d,
                           input int hold, input int flush_at,
                           input logic [31:0] newpc);
    logic [31:0] cur;
    int n;
    int stalls;
    bit done;
    bit flushed;
    cur = pc; n = 0; stalls = 0; done = 0; flushed = 0;
    alat = a; dlat = d; acc_count = 0;
    ce_i = 1; pc_i = pc;
    stall_i = {4'b0, (hold > 0), 1'b0};
    while (!done && n < 60) begin
      flush_i = (n == flush_at);
      cyc();
      if (flush_i) begin
        chk("flush_stallreq", 32'(s_stall), 32'h0);
        flushed = 1;
        cur     = newpc;
        pc_i    = newpc;
        flush_i = 0;
      end else if (!s_stall) begin
        done = 1;
      end else begin
        stalls++;
      end
      n++;
    end
    flush_i = 0;
    chk("fetch_done", 32'(done), 32'h1);
    if (done) begin
      chk("inst_o", s_inst, mem(pmap(cur)));
      chk("bus_addr", acc_last, pmap(cur));
      if (!flushed) begin
        chk("stall_cycles", 32'(stalls), 32'(a + d));
        chk("one_request", 32'(acc_count), 32'h1);
      end
      for (int i = 1; i <= hold; i++) begin
        stall_i[1] = (i < hold);
        cyc();
        chk("hold_stallreq", 32'(s_stall), 32'h0);
        chk("hold_inst", s_inst, mem(pmap(cur)));
        chk("hold_req", 32'(s_req), 32'h0);
      end
    end
    stall_i = 6'h0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; ce_i = 1; pc_i = 32'hBFC0_0000; stall_i = 6'h0; flush_i = 0;
    inst_addr_ok = 0; inst_data_ok = 0; inst_rdata = 32'h0;
    alat = 0; dlat = 1; acc_count = 0; acc_last = 32'h0;
    resp_reset();
    @(negedge clk);
    cyc();
    cyc();
    chk("rst_req", 32'(s_req), 32'h0);
    chk("rst_stallreq", 32'(s_stall), 32'h0);
    chk("rst_inst", s_inst, 32'h0);
    chk("const_wr", 32'(inst_wr), 32'h0);
    chk("const_size", 32'(inst_size), 32'h2);
    chk("const_wdata", inst_wdata, 32'h0);
    rst = 0;

    // T1 best-case fetch
    run_fetch(32'hBFC0_0000, 0, 1, 0, -1, 32'h0);
    // T2 addr_ok after three extra cycles
    run_fetch(32'hBFC0_0000, 3, 1, 0, -1, 32'h0);
    // T3 IF/ID held on delivery, released two cycles later
    run_fetch(32'hBFC0_0010, 0, 1, 2, -1, 32'h0);
    // T4 flush while waiting for data
    run_fetch(32'hBFC0_0020, 0, 3, 0, 1, 32'hBFC0_0380);
    // flush while the request is still unaccepted
    run_fetch(32'hBFC0_0030, 3, 2, 0, 1, 32'hBFC0_0040);
    // flush on the data_ok cycle
    run_fetch(32'hBFC0_0050, 0, 2, 0, 2, 32'hBFC0_0060);
    // T5 kseg0 mapping
    run_fetch(32'h8000_0004, 1, 1, 0, -1, 32'h0);

    // T5 misaligned PC
    ce_i = 1; pc_i = 32'h8000_0002;
    cyc();
    chk("misaligned_req", 32'(s_req), 32'h0);
    chk("misaligned_stallreq", 32'(s_stall), 32'h0);
    chk("misaligned_inst", s_inst, 32'h0);

    // fetch disabled
    ce_i = 0; pc_i = 32'hBFC0_0100;
    cyc();
    chk("ce_off_req", 32'(s_req), 32'h0);
    chk("ce_off_stallreq", 32'(s_stall), 32'h0);

    // T6 reset while the request is pending
    alat = 5; dlat = 1; ce_i = 1; pc_i = 32'hBFC0_0200;
    cyc();
    chk("t6_req_idle", 32'(s_req), 32'h1);
    cyc();
    chk("t6_req_held", 32'(s_req), 32'h1);
    chk("t6_stall_held", 32'(s_stall), 32'h1);
    rst = 1;
    cyc();
    chk("t6_rst_req", 32'(s_req), 32'h0);
    chk("t6_rst_stallreq", 32'(s_stall), 32'h0);
    chk("t6_rst_inst", s_inst, 32'h0);
    rst = 0; ce_i = 0;
    cyc();
    chk("t6_idle_req", 32'(s_req), 32'h0);
    chk("t6_idle_inst", s_inst, 32'h0);
    run_fetch(32'hBFC0_0200, 0, 1, 0, -1, 32'h0);

    // randomized fetches
    for (int k = 0; k < 40; k++) begin
      logic [31:0] rpc;
      logic [31:0] npc;
      int ra;
      int rd;
      int rh;
      int rf;
      rpc = $urandom & 32'hFFFF_FFFC;
      npc = $urandom & 32'hFFFF_FFFC;
      ra  = $urandom_range(0, 3);
      rd  = $urandom_range(1, 3);
      rh  = $urandom_range(0, 2);
      rf  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, ra + rd) : -1;
      run_fetch(rpc, ra, rd, rh, rf, npc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
